mapeo_distancia_filtrado: RTL and testbench

Parametrised successor to the fixed 11-entry distance map. Accepts raw distance samples from the ultrasonic sensor front-end through a valid/ready handshake. Optionally averages them over a power-of-two window, clamps them to the calibrated full-scale distance, and linearly rescales them with rounding to an OUT_W-bit code for the arm servo/PWM stage. The rescale uses a bit-serial divider, so any full-scale distance works without a hand-written table.

---
 rtl/mapeo_distancia_filtrado_pkg.sv | 20 ++
 rtl/mapeo_distancia_filtrado_if.sv | 27 ++
 rtl/mapeo_distancia_filtrado_divisor.sv | 66 ++++++
 rtl/mapeo_distancia_filtrado.sv | 134 +++++++++++++
 tb/tb_mapeo_distancia_filtrado.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mapeo_distancia_filtrado_pkg.sv
// Shared definitions for the distance mapper: FSM states, default widths and
// the dividend width helper that the angle mapper will reuse.
package mapeo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACUM,
        DIV,
        SALIDA
    } estado_t;

    localparam int DIST_IN_W  = 9;
    localparam int DIST_OUT_W = 8;
    localparam int DIST_D_MAX = 10;

    function automatic int ancho_dividendo(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

endpackage

// File: rtl/mapeo_distancia_filtrado_if.sv
// Sample input and mapped output handshakes of the distance mapper.
// The slave side belongs to the mapper; the master side belongs to its environment.
interface mapeo_distancia_filtrado_if #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 8
) ();

    logic [IN_W-1:0]  distancia;
    logic             distancia_valid;
    logic             distancia_ready;
    logic             modo;
    logic [OUT_W-1:0] distancia_mapeada;
    logic             mapeada_valid;
    logic             mapeada_ready;
    logic             saturado;

    modport master (
        output distancia, distancia_valid, modo, mapeada_ready,
        input  distancia_ready, distancia_mapeada, mapeada_valid, saturado
    );

    modport slave (
        input  distancia, distancia_valid, modo, mapeada_ready,
        output distancia_ready, distancia_mapeada, mapeada_valid, saturado
    );

endinterface

// File: rtl/mapeo_distancia_filtrado_divisor.sv
// Sequential restoring divider, one quotient bit per cycle. A start pulse loads the
// operands; o_done pulses for one cycle DIVIDENDO_W cycles later.
module divisor_restaurador #(
    parameter int DIVIDENDO_W = 17,
    parameter int DIVISOR_W   = 9,
    parameter int COCIENTE_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [DIVIDENDO_W-1:0] i_dividendo,
    input  logic [DIVISOR_W-1:0]   i_divisor,
    output logic                   o_done,
    output logic [COCIENTE_W-1:0]  o_cociente
);

    localparam int CNT_W = $clog2(DIVIDENDO_W + 1);

    logic [DIVISOR_W-1:0]   r_resto;
    logic [DIVIDENDO_W-1:0] r_cociente;
    logic [DIVISOR_W-1:0]   r_divisor;
    logic [CNT_W-1:0]       r_cuenta;
    logic                   r_activo;
    logic                   r_done;
    logic [DIVISOR_W:0]     w_parcial;
    logic                   w_cabe;

    // The remainder stays below the divisor, so one extra bit holds the shifted value.
    always_comb begin
        w_parcial = {r_resto, r_cociente[DIVIDENDO_W-1]};
        w_cabe    = (w_parcial >= {1'b0, r_divisor});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resto    <= '0;
            r_cociente <= '0;
            r_divisor  <= '0;
            r_cuenta   <= '0;
            r_activo   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_resto    <= '0;
                r_cociente <= i_dividendo;
                r_divisor  <= i_divisor;
                r_cuenta   <= CNT_W'(DIVIDENDO_W);
                r_activo   <= 1'b1;
            end else if (r_activo) begin
                r_resto    <= w_cabe ? DIVISOR_W'(w_parcial - {1'b0, r_divisor})
                                     : w_parcial[DIVISOR_W-1:0];
                r_cociente <= {r_cociente[DIVIDENDO_W-2:0], w_cabe};
                r_cuenta   <= r_cuenta - 1'b1;
                if (r_cuenta == CNT_W'(1)) begin
                    r_activo <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_cociente = r_cociente[COCIENTE_W-1:0];

endmodule

// File: rtl/mapeo_distancia_filtrado.sv
// Ultrasonic distance to servo code mapper: optional moving average, clamp to the
// calibrated full scale, then a rounded linear rescale through a serial divider.
import mapeo_pkg::*;

module mapeo_distancia_filtrado #(
    parameter int IN_W     = DIST_IN_W,
    parameter int OUT_W    = DIST_OUT_W,
    parameter int D_MAX    = DIST_D_MAX,
    parameter int AVG_LOG2 = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    mapeo_distancia_filtrado_if.slave   io_bus
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = IN_W + AVG_LOG2;
    localparam int DIV_W = ancho_dividendo(IN_W, OUT_W);
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [IN_W-1:0]  DMAX_V = IN_W'(D_MAX);
    localparam logic [DIV_W-1:0] FS_V   = DIV_W'((1 << OUT_W) - 1);
    localparam logic [DIV_W-1:0] MEDIO  = DIV_W'(D_MAX / 2);

    estado_t          r_estado;
    estado_t          w_siguiente;
    logic [IN_W-1:0]  r_muestra;
    logic             r_modo;
    logic [IN_W-1:0]  r_buffer [N];
    logic [SUM_W-1:0] r_suma;
    logic [PTR_W-1:0] r_wptr;
    logic             r_sat_pend;
    logic             r_saturado;
    logic [OUT_W-1:0] r_mapeada;
    logic             w_listo_in;
    logic             w_valido_out;
    logic             w_start;
    logic             w_div_done;
    logic [OUT_W-1:0] w_cociente;
    logic [SUM_W-1:0] w_suma_nueva;
    logic [IN_W-1:0]  w_x_bruto;
    logic             w_sat;
    logic [IN_W-1:0]  w_x;
    logic [DIV_W-1:0] w_dividendo;

    // The oldest entry sits at the write pointer, so the sum is updated in one step.
    always_comb begin
        w_suma_nueva = r_suma - SUM_W'(r_buffer[r_wptr]) + SUM_W'(r_muestra);
        w_x_bruto    = r_modo ? w_suma_nueva[SUM_W-1:AVG_LOG2] : r_muestra;
        w_sat        = (w_x_bruto > DMAX_V);
        w_x          = w_sat ? DMAX_V : w_x_bruto;
        w_dividendo  = DIV_W'(w_x) * FS_V + MEDIO;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_siguiente;
        end
    end

    always_comb begin
        w_siguiente  = r_estado;
        w_listo_in   = 1'b0;
        w_valido_out = 1'b0;
        w_start      = 1'b0;
        case (r_estado)
            IDLE: begin
                w_listo_in = 1'b1;
                if (io_bus.distancia_valid) w_siguiente = ACUM;
            end
            ACUM: begin
                w_start     = 1'b1;
                w_siguiente = DIV;
            end
            DIV: begin
                if (w_div_done) w_siguiente = SALIDA;
            end
            SALIDA: begin
                w_valido_out = 1'b1;
                if (io_bus.mapeada_ready) w_siguiente = IDLE;
            end
            default: w_siguiente = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_muestra  <= '0;
            r_modo     <= 1'b0;
            r_suma     <= '0;
            r_wptr     <= '0;
            r_sat_pend <= 1'b0;
            r_saturado <= 1'b0;
            r_mapeada  <= '0;
            for (int i = 0; i < N; i++) r_buffer[i] <= '0;
        end else begin
            if (r_estado == IDLE && io_bus.distancia_valid) begin
                r_muestra <= io_bus.distancia;
                r_modo    <= io_bus.modo;
            end
            if (r_estado == ACUM) begin
                r_buffer[r_wptr] <= r_muestra;
                r_suma           <= w_suma_nueva;
                r_wptr           <= (AVG_LOG2 == 0) ? '0 : r_wptr + 1'b1;
                r_sat_pend       <= w_sat;
            end
            if (r_estado == DIV && w_div_done) begin
                r_mapeada  <= w_cociente;
                r_saturado <= r_sat_pend;
            end
        end
    end

    divisor_restaurador #(
        .DIVIDENDO_W(DIV_W),
        .DIVISOR_W  (IN_W),
        .COCIENTE_W (OUT_W)
    ) u_divisor (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_dividendo(w_dividendo),
        .i_divisor  (DMAX_V),
        .o_done     (w_div_done),
        .o_cociente (w_cociente)
    );

    assign io_bus.distancia_ready   = w_listo_in;
    assign io_bus.mapeada_valid     = w_valido_out;
    assign io_bus.distancia_mapeada = r_mapeada;
    assign io_bus.saturado          = r_saturado;

endmodule

// File: tb/tb_mapeo_distancia_filtrado.sv
// Scoreboard bench for the distance mapper: default instance plus a 10-bit,
// D_MAX=400 instance. Expected codes are hand-computed round(x*FS/D_MAX).
module tb_mapeo_distancia_filtrado;

    localparam int IN_W    = 9;
    localparam int OUT_W   = 8;
    localparam int OUT_W_B = 10;
    localparam int D_MAX_B = 400;
    localparam int LAT_A   = IN_W + OUT_W + 2;
    localparam int LAT_B   = IN_W + OUT_W_B + 2;

    typedef struct {
        int   dato;
        logic sat;
        int   acc;
    } esperado_t;

    logic clk = 1'b0;
    logic rst;
    int   ciclo = 0;
    int   vectores = 0;
    int   errores = 0;
    esperado_t colaA[$];
    esperado_t colaB[$];
    logic prevA = 1'b0;
    logic prevB = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    mapeo_distancia_filtrado_if #(.IN_W(IN_W), .OUT_W(OUT_W))   busA ();
    mapeo_distancia_filtrado_if #(.IN_W(IN_W), .OUT_W(OUT_W_B)) busB ();

    mapeo_distancia_filtrado dutA (
        .clk   (clk),
        .rst   (rst),
        .io_bus(busA)
    );

    mapeo_distancia_filtrado #(
        .IN_W (IN_W),
        .OUT_W(OUT_W_B),
        .D_MAX(D_MAX_B)
    ) dutB (
        .clk   (clk),
        .rst   (rst),
        .io_bus(busB)
    );

    task automatic checkOutput(input string nombre, input logic [31:0] actual,
                               input logic [31:0] requerido);
        vectores++;
        if (actual !== requerido) begin
            errores++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nombre, actual, requerido);
        end
    endtask

    task automatic reportFail(input string nombre);
        vectores++;
        errores++;
        $display("[TB] FAIL %s", nombre);
    endtask

    // Issues one sample on the chosen instance and, if requested, queues its expected result.
    task automatic applyStimulus(input bit sel, input int dato, input logic modo,
                                 input int exp_dato, input logic exp_sat, input bit registrar);
        int espera = 0;
        esperado_t e;
        @(negedge clk);
        while (!(sel ? busB.distancia_ready : busA.distancia_ready) && espera < 200) begin
            @(negedge clk);
            espera++;
        end
        if (espera >= 200) begin
            reportFail("distancia_ready timeout");
            return;
        end
        if (sel) begin
            busB.distancia = IN_W'(dato); busB.modo = modo; busB.distancia_valid = 1'b1;
        end else begin
            busA.distancia = IN_W'(dato); busA.modo = modo; busA.distancia_valid = 1'b1;
        end
        e.dato = exp_dato; e.sat = exp_sat; e.acc = ciclo + 1;
        if (registrar) begin
            if (sel) colaB.push_back(e);
            else     colaA.push_back(e);
        end
        @(negedge clk);
        busA.distancia_valid = 1'b0;
        busB.distancia_valid = 1'b0;
    endtask

    task automatic waitDrain(input bit sel);
        int espera = 0;
        while ((sel ? colaB.size() : colaA.size()) != 0 && espera < 100) begin
            @(negedge clk);
            espera++;
        end
        if (espera >= 100) begin
            reportFail(sel ? "B output timeout" : "A output timeout");
            if (sel) colaB.delete();
            else     colaA.delete();
        end
        @(negedge clk);
    endtask

    always begin
        esperado_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            prevA = 1'b0;
        end else begin
            if (busA.mapeada_valid && !prevA) begin
                if (colaA.size() == 0) reportFail("A unexpected mapeada_valid");
                else checkOutput("A latency", ciclo - colaA[0].acc, LAT_A);
            end
            if (busA.mapeada_valid && busA.mapeada_ready && colaA.size() > 0) begin
                e = colaA.pop_front();
                checkOutput("A distancia_mapeada", busA.distancia_mapeada, e.dato);
                checkOutput("A saturado", busA.saturado, e.sat);
            end
            prevA = busA.mapeada_valid;
        end
    end

    always begin
        esperado_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            prevB = 1'b0;
        end else begin
            if (busB.mapeada_valid && !prevB) begin
                if (colaB.size() == 0) reportFail("B unexpected mapeada_valid");
                else checkOutput("B latency", ciclo - colaB[0].acc, LAT_B);
            end
            if (busB.mapeada_valid && busB.mapeada_ready && colaB.size() > 0) begin
                e = colaB.pop_front();
                checkOutput("B distancia_mapeada", busB.distancia_mapeada, e.dato);
                checkOutput("B saturado", busB.saturado, e.sat);
            end
            prevB = busB.mapeada_valid;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL global watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int legado[11] = '{0, 26, 51, 77, 102, 128, 153, 179, 204, 230, 255};
        int promedio[4] = '{26, 51, 77, 102};
        int espera;

        rst = 1'b1;
        busA.distancia = '0; busA.distancia_valid = 1'b0; busA.modo = 1'b0; busA.mapeada_ready = 1'b1;
        busB.distancia = '0; busB.distancia_valid = 1'b0; busB.modo = 1'b0; busB.mapeada_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("reset distancia_ready", busA.distancia_ready, 1);
        checkOutput("reset mapeada_valid", busA.mapeada_valid, 0);
        checkOutput("reset distancia_mapeada", busA.distancia_mapeada, 0);
        checkOutput("reset saturado", busA.saturado, 0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, i, 1'b0, legado[i], 1'b0, 1'b1);
            waitDrain(1'b0);
        end

        applyStimulus(1'b0, 300, 1'b0, 255, 1'b1, 1'b1);
        waitDrain(1'b0);
        applyStimulus(1'b0, 10, 1'b0, 255, 1'b0, 1'b1);
        waitDrain(1'b0);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4, 1'b1, promedio[i], 1'b0, 1'b1);
            waitDrain(1'b0);
        end
        applyStimulus(1'b0, 4, 1'b0, 102, 1'b0, 1'b1);
        waitDrain(1'b0);

        // Stall the consumer in SALIDA while a stray sample is offered.
        busA.mapeada_ready = 1'b0;
        applyStimulus(1'b0, 7, 1'b0, 179, 1'b0, 1'b1);
        espera = 0;
        while (!busA.mapeada_valid && espera < 50) begin
            @(negedge clk); #2;
            espera++;
        end
        if (espera >= 50) reportFail("stall mapeada_valid timeout");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            busA.distancia = 9'd3; busA.modo = 1'b0; busA.distancia_valid = 1'b1;
            #2;
            checkOutput("stall distancia_mapeada", busA.distancia_mapeada, 179);
            checkOutput("stall saturado", busA.saturado, 0);
            checkOutput("stall distancia_ready", busA.distancia_ready, 0);
            checkOutput("stall mapeada_valid", busA.mapeada_valid, 1);
        end
        @(negedge clk);
        busA.distancia_valid = 1'b0;
        busA.mapeada_ready = 1'b1;
        @(negedge clk); #2;
        checkOutput("post-handshake distancia_ready", busA.distancia_ready, 1);
        checkOutput("post-handshake mapeada_valid", busA.mapeada_valid, 0);
        repeat (30) @(negedge clk);
        checkOutput("stray sample queue", colaA.size(), 0);

        // Abort a sample mid-division; its result must never appear.
        applyStimulus(1'b0, 5, 1'b1, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        checkOutput("abort mapeada_valid", busA.mapeada_valid, 0);
        checkOutput("abort distancia_ready", busA.distancia_ready, 1);
        checkOutput("abort distancia_mapeada", busA.distancia_mapeada, 0);
        checkOutput("abort saturado", busA.saturado, 0);
        repeat (30) @(negedge clk);
        applyStimulus(1'b0, 8, 1'b1, 51, 1'b0, 1'b1);
        waitDrain(1'b0);

        applyStimulus(1'b1, 200, 1'b0, 512, 1'b0, 1'b1);
        waitDrain(1'b1);
        applyStimulus(1'b1, 450, 1'b0, 1023, 1'b1, 1'b1);
        waitDrain(1'b1);
        applyStimulus(1'b1, 1, 1'b0, 3, 1'b0, 1'b1);
        waitDrain(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectores, errores);
        $finish;
    end

endmodule
